alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//  Shares the single ALU datapath between NREQ requesters (fetch/branch unit, execute stage, ...).
//  - Round-robin grant; one op in flight at a time.
//  - Drives the ALU operand/inst ports and captures the ALU result and flags into a response register.
//  - Owns the architectural flag register (C,L,F,Z,N); writes it only for ops requesting a flag write.
//  - Sits between the decode/issue logic and the ALU instance in the CPU datapath.
// PARAMETERS
//  WIDTH  16  operand/result width; ALU carry is bit WIDTH of the sum
//  NREQ   2   number of requesters (2..4)
// PORTS
//  clk          in   1           system clock, rising edge; the block's one clock
//  reset        in   1           asynchronous, active-high reset
//  req_valid    in   NREQ        request i presents an op
//  req_ready    out  NREQ        one-hot; request i accepted this cycle when valid&ready
//  req_a        in   NREQ*WIDTH  operand 1, slice i = [i*WIDTH +: WIDTH]
//  req_b        in   NREQ*WIDTH  operand 2, same packing
//  req_inst     in   NREQ*4      ALU inst: [2:0] = op (ADD/AND/OR/XOR), [3] = subtract
//  req_flagwr   in   NREQ        op must update the flag register
//  alu_reg1     out  WIDTH       to ALU reg1
//  alu_reg2     out  WIDTH       to ALU reg2
//  alu_inst     out  4           to ALU inst
//  alu_flagwr   out  1           to ALU flagWrite
//  alu_result   in   WIDTH       from ALU result (combinational)
//  alu_flags    in   5           from ALU flagreg: [0]C [1]L [2]F [3]Z [4]N
//  rsp_valid    out  NREQ        one-hot; response for requester i pending
//  rsp_ready    in   NREQ        requester i consumes its response
//  rsp_result   out  WIDTH       captured result, shared by all requesters
//  rsp_flags    out  5           flags produced by this op (valid even when flagwr=0)
//  flags_q      out  5           architectural flag register
//  busy         out  1           state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE, last_grant=NREQ-1 (requester 0 wins first), all outputs 0, flags_q=0.
//  - FSM IDLE -> EXEC -> RESP -> IDLE.
//  - IDLE:
//    - If any req_valid, grant the first valid index after last_grant (wrapping modulo NREQ).
//    - Assert req_ready only for the granted index, combinationally in that cycle.
//    - Latch a/b/inst/flagwr and grant id into op registers; update last_grant; go to EXEC.
//    - If no req_valid, stay in IDLE with req_ready=0.
//  - EXEC:
//    - alu_* driven from the op registers; alu_* are 0 in all other states.
//    - Capture alu_result -> rsp_result and alu_flags -> rsp_flags.
//    - If flagwr, flags_q <= alu_flags; otherwise flags_q is held.
//    - Go to RESP.
//  - RESP:
//    - rsp_valid[grant]=1 until rsp_ready[grant]; rsp_ready on other bits is ignored.
//    - On handshake, go to IDLE. The next grant can happen in the following cycle.
//  - Latency: accept at cycle t, rsp_valid at t+2. Best-case throughput is 1 op per 3 cycles.
//  - Requests not granted are held by their requesters; no request is ever dropped.
//  - Fairness: with all NREQ requesting continuously, grants strictly rotate.
//  - Width: no carry is kept beyond alu_flags[0]; rsp_result is exactly WIDTH bits.
//  - inst[2:0] in 4..7: passed through unchanged; the ALU returns 0 and the response is still
//    generated.
//  - Reset asserted mid-op: return to IDLE immediately; the pending response is lost; flags_q=0.
//  - A requester deasserting req_valid after acceptance has no effect on the op in flight.
// STRUCTURE
//  - Package tron_alu_pkg:
//    - ALU op localparams: OP_ADD=3'd0, OP_AND=3'd1, OP_OR=3'd2, OP_XOR=3'd3, INST_SUB_BIT=3.
//    - Flag index constants: FLAG_C=0, FLAG_L=1, FLAG_F=2, FLAG_Z=3, FLAG_N=4.
//    - FSM state encoding: ST_IDLE, ST_EXEC, ST_RESP.
//  - Sub-module rr_arbiter #(NREQ): inputs req vector and last_grant; outputs one-hot grant and
//    grant index. Purely combinational; last_grant is held in the parent.
//  - The ALU instance stays outside this block; it is wired up in the CPU top level.
// TESTING (bench instantiates the real ALU)
//  1. Subtract: req0 a=0x0005, b=0x0003, inst=4'b1000, flagwr=1
//     -> rsp_valid[0] at t+2, result 0x0002, rsp_flags=5'b00011, flags_q=5'b00011.
//  2. Add with wrap: req1 a=0xFFFF, b=0x0001, inst=0, flagwr=1
//     -> result 0x0000, flags 5'b01011 (C, L, Z set).
//  3. No flag write: after scenario 1, req0 XOR a=0x00F0, b=0x0F00, flagwr=0
//     -> result 0x0FF0; flags_q still 5'b00011.
//  4. Contention: both valid continuously, rsp_ready=1 -> grants 0,1,0,1.
//     - Each requester is accepted every 6 cycles; no request is starved.
//  5. Backpressure: hold rsp_ready=0 for 5 cycles in RESP
//     -> rsp_valid and rsp_result stable; req_ready=0 for all; busy=1.
//  6. Reset asserted during EXEC
//     -> next cycle: state IDLE, rsp_valid=0, flags_q=0, and req0 is granted first afterwards.

Source files
------------

// File: rtl/tron_alu_pkg.sv
// Shared constants and types for the ALU share arbiter: ALU op encodings,
// flag bit positions and the arbiter FSM state encoding.
package tron_alu_pkg;

   localparam logic [2:0] OP_ADD       = 3'd0;
   localparam logic [2:0] OP_AND       = 3'd1;
   localparam logic [2:0] OP_OR        = 3'd2;
   localparam logic [2:0] OP_XOR       = 3'd3;
   localparam int         INST_SUB_BIT = 3;

   localparam int FLAG_C = 0;
   localparam int FLAG_L = 1;
   localparam int FLAG_F = 2;
   localparam int FLAG_Z = 3;
   localparam int FLAG_N = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   function automatic logic [4:0] flag_update(input logic       wr,
                                              input logic [4:0] cur,
                                              input logic [4:0] nxt);
      logic [4:0] res;
      if (wr) begin
         res = nxt;
      end else begin
         res = cur;
      end
      return res;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first requesting index after
// last_grant_i (wrapping) wins. The caller owns the last_grant register.
module rr_arbiter #(
   parameter int NREQ = 2,
   parameter int IDXW = (NREQ > 2) ? 2 : 1
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IDXW-1:0] last_grant_i,
   output logic [NREQ-1:0] grant_o,
   output logic [IDXW-1:0] grant_idx_o
);

   logic [IDXW-1:0] cand_s;
   logic            found_s;

   // Scan candidates in rotating priority order starting just after the last winner.
   always_comb begin
      grant_o     = '0;
      grant_idx_o = '0;
      cand_s      = '0;
      found_s     = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         cand_s = IDXW'((32'(last_grant_i) + 32'(k)) % 32'(NREQ));
         if (!found_s && req_i[cand_s]) begin
            found_s         = 1'b1;
            grant_o[cand_s] = 1'b1;
            grant_idx_o     = cand_s;
         end else begin
            found_s = found_s;
         end
      end
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between NREQ requesters: round-robin grant, one op in flight,
// response register with captured result/flags, and the architectural flag register.
module alu_share_arbiter
   import tron_alu_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int NREQ  = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   input  logic [NREQ*4-1:0]     req_inst,
   input  logic [NREQ-1:0]       req_flagwr,
   output logic [WIDTH-1:0]      alu_reg1,
   output logic [WIDTH-1:0]      alu_reg2,
   output logic [3:0]            alu_inst,
   output logic                  alu_flagwr,
   input  logic [WIDTH-1:0]      alu_result,
   input  logic [4:0]            alu_flags,
   output logic [NREQ-1:0]       rsp_valid,
   input  logic [NREQ-1:0]       rsp_ready,
   output logic [WIDTH-1:0]      rsp_result,
   output logic [4:0]            rsp_flags,
   output logic [4:0]            flags_q,
   output logic                  busy
);

   localparam int IDXW = (NREQ > 2) ? 2 : 1;

   state_e            state_q,      state_d;
   logic [IDXW-1:0]   last_grant_q, last_grant_d;
   logic [IDXW-1:0]   op_id_q,      op_id_d;
   logic [WIDTH-1:0]  op_a_q,       op_a_d;
   logic [WIDTH-1:0]  op_b_q,       op_b_d;
   logic [3:0]        op_inst_q,    op_inst_d;
   logic              op_flagwr_q,  op_flagwr_d;
   logic [NREQ-1:0]   rsp_valid_q,  rsp_valid_d;
   logic [WIDTH-1:0]  rsp_result_q, rsp_result_d;
   logic [4:0]        rsp_flags_q,  rsp_flags_d;
   logic [4:0]        flag_arch_q,  flag_arch_d;
   logic [NREQ-1:0]   req_ready_s;
   logic [NREQ-1:0]   grant_s;
   logic [IDXW-1:0]   grant_idx_s;

   rr_arbiter #(
      .NREQ (NREQ),
      .IDXW (IDXW)
   ) u_rr_arbiter (
      .req_i        (req_valid),
      .last_grant_i (last_grant_q),
      .grant_o      (grant_s),
      .grant_idx_o  (grant_idx_s)
   );

   // Op registers are cleared when leaving EXEC, so the ALU sees zeros outside EXEC.
   assign alu_reg1   = op_a_q;
   assign alu_reg2   = op_b_q;
   assign alu_inst   = op_inst_q;
   assign alu_flagwr = op_flagwr_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_result = rsp_result_q;
   assign rsp_flags  = rsp_flags_q;
   assign flags_q    = flag_arch_q;
   assign busy       = (state_q != ST_IDLE);
   assign req_ready  = req_ready_s & {NREQ{~reset}};

   // Next-state, grant acceptance, result capture and response handshake.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      op_id_d      = op_id_q;
      op_a_d       = op_a_q;
      op_b_d       = op_b_q;
      op_inst_d    = op_inst_q;
      op_flagwr_d  = op_flagwr_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_result_d = rsp_result_q;
      rsp_flags_d  = rsp_flags_q;
      flag_arch_d  = flag_arch_q;
      req_ready_s  = '0;
      case (state_q)
         ST_IDLE: begin
            if (|req_valid) begin
               req_ready_s  = grant_s;
               op_a_d       = req_a[grant_idx_s*WIDTH +: WIDTH];
               op_b_d       = req_b[grant_idx_s*WIDTH +: WIDTH];
               op_inst_d    = req_inst[grant_idx_s*4 +: 4];
               op_flagwr_d  = req_flagwr[grant_idx_s];
               op_id_d      = grant_idx_s;
               last_grant_d = grant_idx_s;
               state_d      = ST_EXEC;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_EXEC: begin
            rsp_result_d          = alu_result;
            rsp_flags_d           = alu_flags;
            flag_arch_d           = flag_update(op_flagwr_q, flag_arch_q, alu_flags);
            rsp_valid_d           = '0;
            rsp_valid_d[op_id_q]  = 1'b1;
            op_a_d                = '0;
            op_b_d                = '0;
            op_inst_d             = 4'd0;
            op_flagwr_d           = 1'b0;
            state_d               = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready[op_id_q]) begin
               rsp_valid_d = '0;
               state_d     = ST_IDLE;
            end else begin
               state_d = ST_RESP;
            end
         end
         default: begin
            rsp_valid_d = '0;
            op_a_d      = '0;
            op_b_d      = '0;
            op_inst_d   = 4'd0;
            op_flagwr_d = 1'b0;
            state_d     = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset drops any op in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         last_grant_q <= IDXW'(NREQ - 1);
         op_id_q      <= '0;
         op_a_q       <= '0;
         op_b_q       <= '0;
         op_inst_q    <= 4'd0;
         op_flagwr_q  <= 1'b0;
         rsp_valid_q  <= '0;
         rsp_result_q <= '0;
         rsp_flags_q  <= 5'd0;
         flag_arch_q  <= 5'd0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         op_id_q      <= op_id_d;
         op_a_q       <= op_a_d;
         op_b_q       <= op_b_d;
         op_inst_q    <= op_inst_d;
         op_flagwr_q  <= op_flagwr_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_result_q <= rsp_result_d;
         rsp_flags_q  <= rsp_flags_d;
         flag_arch_q  <= flag_arch_d;
      end
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural 16-bit ALU model
// (C carry, L a>b unsigned, F signed overflow, Z zero, N sign; ops 4..7 give 0).
module tb_alu_share_arbiter;
   import tron_alu_pkg::*;

   localparam int WIDTH = 16;
   localparam int NREQ  = 2;

   logic                  clk;
   logic                  reset;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*WIDTH-1:0] req_a;
   logic [NREQ*WIDTH-1:0] req_b;
   logic [NREQ*4-1:0]     req_inst;
   logic [NREQ-1:0]       req_flagwr;
   logic [WIDTH-1:0]      alu_reg1;
   logic [WIDTH-1:0]      alu_reg2;
   logic [3:0]            alu_inst;
   logic                  alu_flagwr;
   logic [WIDTH-1:0]      alu_result;
   logic [4:0]            alu_flags;
   logic [NREQ-1:0]       rsp_valid;
   logic [NREQ-1:0]       rsp_ready;
   logic [WIDTH-1:0]      rsp_result;
   logic [4:0]            rsp_flags;
   logic [4:0]            flags_q;
   logic                  busy;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [WIDTH:0]   sum_s;
   logic [WIDTH-1:0] opb_s;

   alu_share_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_inst   (req_inst),
      .req_flagwr (req_flagwr),
      .alu_reg1   (alu_reg1),
      .alu_reg2   (alu_reg2),
      .alu_inst   (alu_inst),
      .alu_flagwr (alu_flagwr),
      .alu_result (alu_result),
      .alu_flags  (alu_flags),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_result (rsp_result),
      .rsp_flags  (rsp_flags),
      .flags_q    (flags_q),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural ALU standing in for the CPU's ALU instance.
   always_comb begin
      opb_s      = alu_inst[INST_SUB_BIT] ? ~alu_reg2 : alu_reg2;
      sum_s      = {1'b0, alu_reg1} + {1'b0, opb_s} + {16'd0, alu_inst[INST_SUB_BIT]};
      alu_result = 16'd0;
      alu_flags  = 5'd0;
      case (alu_inst[2:0])
         OP_ADD: begin
            alu_result     = sum_s[WIDTH-1:0];
            alu_flags[FLAG_C] = sum_s[WIDTH];
            alu_flags[FLAG_F] = (alu_reg1[WIDTH-1] == opb_s[WIDTH-1]) &&
                                (sum_s[WIDTH-1] != alu_reg1[WIDTH-1]);
         end
         OP_AND:  alu_result = alu_reg1 & alu_reg2;
         OP_OR:   alu_result = alu_reg1 | alu_reg2;
         OP_XOR:  alu_result = alu_reg1 ^ alu_reg2;
         default: alu_result = 16'd0;
      endcase
      if (alu_inst[2:0] <= OP_XOR) begin
         alu_flags[FLAG_L] = (alu_reg1 > alu_reg2);
         alu_flags[FLAG_Z] = (alu_result == 16'd0);
         alu_flags[FLAG_N] = alu_result[WIDTH-1];
      end else begin
         alu_flags = 5'd0;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] inst, input logic fw);
      req_a[i*WIDTH +: WIDTH] = a;
      req_b[i*WIDTH +: WIDTH] = b;
      req_inst[i*4 +: 4]      = inst;
      req_flagwr[i]           = fw;
   endtask

   initial begin
      logic [1:0] exp_g;
      reset      = 1'b1;
      req_valid  = 2'b00;
      req_a      = '0;
      req_b      = '0;
      req_inst   = '0;
      req_flagwr = '0;
      rsp_ready  = 2'b00;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_busy",      32'(busy),       32'd0);
      check("rst_rsp_valid", 32'(rsp_valid),  32'd0);
      check("rst_flags_q",   32'(flags_q),    32'd0);
      check("rst_req_ready", 32'(req_ready),  32'd0);
      check("rst_alu_reg1",  32'(alu_reg1),   32'd0);
      check("rst_alu_inst",  32'(alu_inst),   32'd0);
      check("rst_result",    32'(rsp_result), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);

      // Scenario 1: subtract 5-3 from req0 with flag write
      set_req(0, 16'h0005, 16'h0003, 4'b1000, 1'b1);
      req_valid = 2'b01;
      #1 check("s1_req_ready", 32'(req_ready), 32'h1);
      @(negedge clk);
      req_valid = 2'b00;
      check("s1_alu_reg1",   32'(alu_reg1),   32'h5);
      check("s1_alu_reg2",   32'(alu_reg2),   32'h3);
      check("s1_alu_inst",   32'(alu_inst),   32'h8);
      check("s1_alu_flagwr", 32'(alu_flagwr), 32'h1);
      check("s1_busy_exec",  32'(busy),       32'h1);
      check("s1_no_rsp_yet", 32'(rsp_valid),  32'h0);
      @(negedge clk);
      check("s1_rsp_valid",  32'(rsp_valid),  32'h1);
      check("s1_result",     32'(rsp_result), 32'h0002);
      check("s1_rsp_flags",  32'(rsp_flags),  32'h03);
      check("s1_flags_q",    32'(flags_q),    32'h03);
      check("s1_alu_idle",   32'(alu_reg1),   32'h0);
      rsp_ready = 2'b01;
      @(negedge clk);
      rsp_ready = 2'b00;
      check("s1_done_busy",  32'(busy),       32'h0);
      check("s1_done_valid", 32'(rsp_valid),  32'h0);

      // Scenario 3: XOR without flag write keeps flags_q
      set_req(0, 16'h00F0, 16'h0F00, 4'b0011, 1'b0);
      req_valid = 2'b01;
      #1 check("s3_req_ready", 32'(req_ready), 32'h1);
      @(negedge clk);
      req_valid = 2'b00;
      @(negedge clk);
      check("s3_result",    32'(rsp_result), 32'h0FF0);
      check("s3_rsp_flags", 32'(rsp_flags),  32'h00);
      check("s3_flags_q",   32'(flags_q),    32'h03);
      rsp_ready = 2'b01;
      @(negedge clk);
      rsp_ready = 2'b00;

      // Scenario 2: add with wrap from req1; wrong-bit rsp_ready is ignored
      set_req(1, 16'hFFFF, 16'h0001, 4'b0000, 1'b1);
      req_valid = 2'b10;
      #1 check("s2_req_ready", 32'(req_ready), 32'h2);
      @(negedge clk);
      req_valid = 2'b00;
      @(negedge clk);
      check("s2_rsp_valid", 32'(rsp_valid),  32'h2);
      check("s2_result",    32'(rsp_result), 32'h0000);
      check("s2_rsp_flags", 32'(rsp_flags),  32'h0B);
      check("s2_flags_q",   32'(flags_q),    32'h0B);
      rsp_ready = 2'b01;
      @(negedge clk);
      check("s2_ignore_other_ready", 32'(rsp_valid), 32'h2);
      check("s2_still_busy",         32'(busy),      32'h1);
      rsp_ready = 2'b10;
      @(negedge clk);
      rsp_ready = 2'b00;
      check("s2_done_busy", 32'(busy), 32'h0);

      // Scenario 4: contention, grants rotate 0,1,0,1 every 3 cycles
      set_req(0, 16'h0001, 16'h0002, 4'b0000, 1'b0);
      set_req(1, 16'h0FF0, 16'h00FF, 4'b0001, 1'b0);
      req_valid = 2'b11;
      rsp_ready = 2'b11;
      for (int g = 0; g < 4; g++) begin
         exp_g = g[0] ? 2'b10 : 2'b01;
         #1 check("s4_grant", 32'(req_ready), 32'(exp_g));
         @(negedge clk);
         @(negedge clk);
         check("s4_rsp_valid", 32'(rsp_valid), 32'(exp_g));
         check("s4_result", 32'(rsp_result), g[0] ? 32'h00F0 : 32'h0003);
         @(negedge clk);
         if (g == 3) req_valid = 2'b00;
      end
      rsp_ready = 2'b00;
      check("s4_flags_held", 32'(flags_q), 32'h0B);
      check("s4_idle",       32'(busy),    32'h0);

      // Scenario 5: backpressure in RESP for 5 cycles with both requesters waiting
      set_req(0, 16'h1234, 16'h0F0F, 4'b0010, 1'b0);
      req_valid = 2'b11;
      #1 check("s5_req_ready", 32'(req_ready), 32'h1);
      @(negedge clk);
      @(negedge clk);
      for (int c = 0; c < 5; c++) begin
         check("s5_rsp_valid", 32'(rsp_valid),  32'h1);
         check("s5_result",    32'(rsp_result), 32'h1F3F);
         check("s5_req_ready", 32'(req_ready),  32'h0);
         check("s5_busy",      32'(busy),       32'h1);
         @(negedge clk);
      end
      check("s5_rsp_flags", 32'(rsp_flags), 32'h02);
      rsp_ready = 2'b01;
      req_valid = 2'b00;
      @(negedge clk);
      rsp_ready = 2'b00;
      check("s5_done_busy",  32'(busy),      32'h0);
      check("s5_done_valid", 32'(rsp_valid), 32'h0);

      // Unused op code 5 is passed through and still answered
      set_req(1, 16'h0001, 16'h0001, 4'b0101, 1'b0);
      req_valid = 2'b10;
      #1 check("inv_req_ready", 32'(req_ready), 32'h2);
      @(negedge clk);
      req_valid = 2'b00;
      check("inv_alu_inst", 32'(alu_inst), 32'h5);
      @(negedge clk);
      check("inv_rsp_valid", 32'(rsp_valid),  32'h2);
      check("inv_result",    32'(rsp_result), 32'h0000);
      check("inv_flags_q",   32'(flags_q),    32'h0B);
      rsp_ready = 2'b10;
      @(negedge clk);
      rsp_ready = 2'b00;

      // Scenario 6: reset during EXEC
      set_req(0, 16'h0005, 16'h0003, 4'b1000, 1'b1);
      req_valid = 2'b01;
      #1 check("s6_req_ready", 32'(req_ready), 32'h1);
      @(negedge clk);
      req_valid = 2'b00;
      check("s6_exec_busy", 32'(busy), 32'h1);
      #2 reset = 1'b1;
      #1 check("s6_async_busy", 32'(busy), 32'h0);
      @(negedge clk);
      check("s6_busy",      32'(busy),      32'h0);
      check("s6_rsp_valid", 32'(rsp_valid), 32'h0);
      check("s6_flags_q",   32'(flags_q),   32'h0);
      check("s6_alu_reg1",  32'(alu_reg1),  32'h0);
      reset = 1'b0;
      set_req(1, 16'h0002, 16'h0002, 4'b0000, 1'b0);
      req_valid = 2'b11;
      #1 check("s6_first_grant", 32'(req_ready), 32'h1);
      @(negedge clk);
      req_valid = 2'b00;
      @(negedge clk);
      check("s6_rsp_valid2", 32'(rsp_valid),  32'h1);
      check("s6_result2",    32'(rsp_result), 32'h0002);
      check("s6_flags_q2",   32'(flags_q),    32'h03);
      rsp_ready = 2'b01;
      @(negedge clk);
      rsp_ready = 2'b00;
      check("s6_done_busy", 32'(busy), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
